// File: rtl/fsm_counter_core_pkg.sv
// Shared definitions for FSM-based control cores.
//
// Contents:
//   STATE_W  - width of the controller state register (2 bits)
//   state_t  - state encoding: S_IDLE=00, S_RUN=01, S_DONE=10.
//              The encoding 11 is unused and leads back to S_IDLE.
package fsm_counter_core_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/fsm_counter_core_run_counter.sv
// run_counter: run-length counter used by the control FSM.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   synchronous active-low reset (counter=0, latched N=0)
//   load      in   capture load_val as the run length N and clear the counter
//   load_val  in   run length N to capture on load
//   clear     in   force the counter to 0
//   enable    in   increment the counter by one
//   cnt       out  current counter value
//   is_done   out  high when the counter sits on the terminal value N-1
//
// Priority: reset, load, clear, enable.
module run_counter
  import fsm_counter_core_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 clear,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 is_done
);

  logic [CNT_WIDTH-1:0] num_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt   <= '0;
      num_q <= '0;
    end else if (load) begin
      num_q <= load_val;
      cnt   <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  // The FSM only consults is_done in RUN, where N >= 1, so N-1 never
  // underflows in a way that matters and the counter never wraps.
  assign is_done = (cnt == (num_q - CNT_WIDTH'(1)));

endmodule

// File: rtl/fsm_counter_core.sv
// fsm_counter_core: IDLE/RUN/DONE controller with an internal run counter.
//
// A start request in IDLE latches a run length N; the core stays in RUN for
// exactly N cycles (o_cnt = 0..N-1), spends one cycle in DONE, then returns
// to IDLE. N=0 goes straight to DONE. i_abort leaves RUN/DONE (and blocks a
// start in IDLE) without a done pulse.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   synchronous active-low reset
//   i_run      in   start request, honoured only in IDLE
//   i_num_cnt  in   run length N, sampled together with i_run
//   i_abort    in   synchronous abort back to IDLE
//   o_idle     out  state is IDLE
//   o_running  out  state is RUN
//   o_done     out  state is DONE (one-cycle pulse)
//   o_cnt      out  counter value, 0 outside RUN
//   dbg_state  out  raw state register for observation
module fsm_counter_core
  import fsm_counter_core_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_run,
  input  logic [CNT_WIDTH-1:0] i_num_cnt,
  input  logic                 i_abort,
  output logic                 o_idle,
  output logic                 o_running,
  output logic                 o_done,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic [STATE_W-1:0]   dbg_state
);

  state_t               state;
  state_t               next_state;
  logic                 cnt_load;
  logic                 cnt_clear;
  logic                 cnt_enable;
  logic                 cnt_is_done;
  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = S_IDLE;
    cnt_load   = 1'b0;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    case (state)
      S_IDLE: begin
        // Abort beats a simultaneous start request.
        if (i_abort) begin
          next_state = S_IDLE;
        end else if (i_run) begin
          if (i_num_cnt != '0) begin
            next_state = S_RUN;
            cnt_load   = 1'b1;
          end else begin
            next_state = S_DONE;
          end
        end else begin
          next_state = S_IDLE;
        end
      end
      S_RUN: begin
        // Abort beats completion; both exits leave the counter at 0.
        if (i_abort) begin
          next_state = S_IDLE;
          cnt_clear  = 1'b1;
        end else if (cnt_is_done) begin
          next_state = S_DONE;
          cnt_clear  = 1'b1;
        end else begin
          next_state = S_RUN;
          cnt_enable = 1'b1;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
        cnt_clear  = 1'b1;
      end
      default: begin
        next_state = S_IDLE;
        cnt_clear  = 1'b1;
      end
    endcase
  end

  run_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_run_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (i_num_cnt),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .cnt      (cnt),
    .is_done  (cnt_is_done)
  );

  // Moore outputs decoded from the current state only.
  assign o_idle    = (state == S_IDLE);
  assign o_running = (state == S_RUN);
  assign o_done    = (state == S_DONE);
  assign o_cnt     = cnt;
  assign dbg_state = state;

endmodule

// File: tb/tb_fsm_counter_core.sv
// Self-checking bench for fsm_counter_core.
// Instance a uses CNT_WIDTH=8 for the functional sequence; instance b uses
// CNT_WIDTH=4 for the maximum-length run. Each directed step pushes the
// outputs expected after the next rising edge, and tick() pops and compares.
module tb_fsm_counter_core;

  logic       clk = 1'b0;
  logic       reset_n;

  logic       a_run, a_abort;
  logic [7:0] a_num;
  logic       a_idle, a_running, a_done;
  logic [7:0] a_cnt;
  logic [1:0] a_state;

  logic       b_run, b_abort;
  logic [3:0] b_num;
  logic       b_idle, b_running, b_done;
  logic [3:0] b_cnt;
  logic [1:0] b_state;

  int tests = 0;
  int fails = 0;

  // Expected {idle, running, done, cnt} after the next edge.
  logic [10:0] exp_q[$];
  string       tag_q[$];
  logic [6:0]  exp_b_q[$];
  string       tag_b_q[$];

  always #5 clk = ~clk;

  fsm_counter_core #(.CNT_WIDTH(8)) dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_run     (a_run),
    .i_num_cnt (a_num),
    .i_abort   (a_abort),
    .o_idle    (a_idle),
    .o_running (a_running),
    .o_done    (a_done),
    .o_cnt     (a_cnt),
    .dbg_state (a_state)
  );

  fsm_counter_core #(.CNT_WIDTH(4)) dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_run     (b_run),
    .i_num_cnt (b_num),
    .i_abort   (b_abort),
    .o_idle    (b_idle),
    .o_running (b_running),
    .o_done    (b_done),
    .o_cnt     (b_cnt),
    .dbg_state (b_state)
  );

  // ---------------- driver / expectation tasks ----------------
  task automatic exp_a(input string tag, input logic i, input logic r,
                       input logic d, input logic [7:0] c);
    exp_q.push_back({i, r, d, c});
    tag_q.push_back(tag);
  endtask

  task automatic a_idle_exp(input string tag);
    exp_a(tag, 1'b1, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic a_run_exp(input string tag, input int c);
    exp_a(tag, 1'b0, 1'b1, 1'b0, 8'(c));
  endtask

  task automatic a_done_exp(input string tag);
    exp_a(tag, 1'b0, 1'b0, 1'b1, 8'd0);
  endtask

  task automatic exp_b(input string tag, input logic i, input logic r,
                       input logic d, input logic [3:0] c);
    exp_b_q.push_back({i, r, d, c});
    tag_b_q.push_back(tag);
  endtask

  // ---------------- scoreboard ----------------
  task automatic tick();
    logic [10:0] e;
    logic [6:0]  eb;
    string       t;
    @(posedge clk);
    #1;
    tests++;
    assert ($onehot({a_idle, a_running, a_done})) else begin
      fails++;
      $error("FAIL onehot_a: observed %b required exactly one of idle/running/done",
             {a_idle, a_running, a_done});
    end
    tests++;
    assert ($onehot({b_idle, b_running, b_done})) else begin
      fails++;
      $error("FAIL onehot_b: observed %b required exactly one of idle/running/done",
             {b_idle, b_running, b_done});
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      tests++;
      assert ({a_idle, a_running, a_done, a_cnt} === e) else begin
        fails++;
        $error("FAIL %s: observed idle/run/done=%b cnt=%0d, expected idle/run/done=%b cnt=%0d",
               t, {a_idle, a_running, a_done}, a_cnt, e[10:8], e[7:0]);
      end
      tests++;
      assert (a_state === {e[8], e[9]}) else begin
        fails++;
        $error("FAIL %s_state: observed %b expected %b", t, a_state, {e[8], e[9]});
      end
    end
    if (exp_b_q.size() > 0) begin
      eb = exp_b_q.pop_front();
      t  = tag_b_q.pop_front();
      tests++;
      assert ({b_idle, b_running, b_done, b_cnt} === eb) else begin
        fails++;
        $error("FAIL %s: observed idle/run/done=%b cnt=%0d, expected idle/run/done=%b cnt=%0d",
               t, {b_idle, b_running, b_done}, b_cnt, eb[6:4], eb[3:0]);
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    reset_n = 1'b0;
    a_run = 1'b0; a_abort = 1'b0; a_num = 8'd0;
    b_run = 1'b0; b_abort = 1'b0; b_num = 4'd0;

    // Reset state
    a_idle_exp("reset0"); exp_b("reset_b", 1'b1, 1'b0, 1'b0, 4'd0); tick();
    a_idle_exp("reset1"); tick();
    reset_n = 1'b1;
    a_idle_exp("idle_after_reset"); tick();

    // Basic run N=4: RUN 0..3, DONE at edge k+5, then IDLE
    a_run = 1'b1; a_num = 8'd4;
    a_run_exp("basic_run", 0); tick();
    a_run = 1'b0;
    for (int i = 1; i < 4; i++) begin a_run_exp("basic_run", i); tick(); end
    a_done_exp("basic_done"); tick();
    a_idle_exp("basic_idle"); tick();
    a_idle_exp("basic_idle2"); tick();

    // Zero length: DONE on the very next cycle
    a_run = 1'b1; a_num = 8'd0;
    a_done_exp("zero_done"); tick();
    a_run = 1'b0;
    a_idle_exp("zero_idle"); tick();

    // Ignored inputs: N=6, then i_num_cnt=2 and an i_run pulse mid-run
    a_run = 1'b1; a_num = 8'd6;
    a_run_exp("ign_run", 0); tick();
    a_run = 1'b0; a_num = 8'd2;
    for (int i = 1; i < 6; i++) begin
      a_run = (i == 2);
      a_run_exp("ign_run", i); tick();
    end
    a_run = 1'b0;
    a_done_exp("ign_done"); tick();
    a_idle_exp("ign_idle"); tick();

    // i_run held high through DONE: one IDLE cycle between runs
    a_run = 1'b1; a_num = 8'd1;
    a_run_exp("hold_run1", 0); tick();
    a_done_exp("hold_done1"); tick();
    a_idle_exp("hold_gap"); tick();
    a_run_exp("hold_run2", 0); tick();
    a_run = 1'b0;
    a_done_exp("hold_done2"); tick();
    a_idle_exp("hold_idle"); tick();

    // Abort N=10 when o_cnt=3
    a_run = 1'b1; a_num = 8'd10;
    a_run_exp("abort_run", 0); tick();
    a_run = 1'b0;
    for (int i = 1; i < 4; i++) begin a_run_exp("abort_run", i); tick(); end
    a_abort = 1'b1;
    a_idle_exp("abort_idle"); tick();
    a_abort = 1'b0;
    for (int i = 0; i < 3; i++) begin a_idle_exp("abort_no_done"); tick(); end

    // Abort on the terminal count beats completion (N=3, abort at cnt=2)
    a_run = 1'b1; a_num = 8'd3;
    a_run_exp("abort_term_run", 0); tick();
    a_run = 1'b0;
    for (int i = 1; i < 3; i++) begin a_run_exp("abort_term_run", i); tick(); end
    a_abort = 1'b1;
    a_idle_exp("abort_term_idle"); tick();
    a_abort = 1'b0;
    a_idle_exp("abort_term_no_done"); tick();

    // Abort in DONE (N=0 start)
    a_run = 1'b1; a_num = 8'd0;
    a_done_exp("abort_done_enter"); tick();
    a_run = 1'b0; a_abort = 1'b1;
    a_idle_exp("abort_done_idle"); tick();

    // Abort and run together in IDLE: stay IDLE
    a_run = 1'b1; a_abort = 1'b1; a_num = 8'd5;
    a_idle_exp("abort_vs_run"); tick();
    a_run = 1'b0; a_abort = 1'b0;
    a_idle_exp("abort_vs_run2"); tick();

    // Reset held 3 cycles mid-run (N=5): no done pulse
    a_run = 1'b1; a_num = 8'd5;
    a_run_exp("rst_mid_run", 0); tick();
    a_run = 1'b0;
    a_run_exp("rst_mid_run", 1); tick();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin a_idle_exp("rst_mid_held"); tick(); end
    reset_n = 1'b1;
    a_idle_exp("rst_mid_after"); tick();
    a_idle_exp("rst_mid_no_done"); tick();

    // Maximum length on the 4-bit instance: N=15, cnt peaks at 14
    b_run = 1'b1; b_num = 4'd15;
    exp_b("max_run", 1'b0, 1'b1, 1'b0, 4'd0); tick();
    b_run = 1'b0;
    for (int i = 1; i < 15; i++) begin
      exp_b("max_run", 1'b0, 1'b1, 1'b0, 4'(i)); tick();
    end
    exp_b("max_done", 1'b0, 1'b0, 1'b1, 4'd0); tick();
    exp_b("max_idle", 1'b1, 1'b0, 1'b0, 4'd0); tick();
    exp_b("max_idle2", 1'b1, 1'b0, 1'b0, 4'd0); tick();

    // Random run lengths with i_num_cnt scrambled mid-run
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 20);
      a_run = 1'b1; a_num = 8'(n);
      a_run_exp("rand_run", 0); tick();
      a_run = 1'b0;
      for (int i = 1; i < n; i++) begin
        a_num = 8'($urandom_range(0, 255));
        a_run_exp("rand_run", i); tick();
      end
      a_done_exp("rand_done"); tick();
      a_idle_exp("rand_idle"); tick();
    end

    tests++;
    assert (exp_q.size() == 0 && exp_b_q.size() == 0) else begin
      fails++;
      $error("FAIL queue_drain: observed %0d/%0d entries left, expected 0/0",
             exp_q.size(), exp_b_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
